maze_grid_renderer: RTL

- Parametrised maze-map store plus pixel colouriser for the VGA path.
- Holds a GRID_COLS x GRID_ROWS array of STATE_W-bit cell codes, written from the radio decoder via a valid/ready port.
- Maps each VGA pixel coordinate to an RGB332 colour through a 2-stage pipeline.
- Adds a bulk-clear sequencer, cell grid lines and out-of-range write accounting.

---
 rtl/maze_pkg.sv | 26 ++
 rtl/maze_clear_seq.sv | 66 ++++++
 rtl/maze_grid_renderer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze map renderer: RGB332 colour constants,
// the cell-code palette and the bulk-clear FSM state encoding.
// Optional cursor highlight is enabled by defining MAZE_CURSOR_HIGHLIGHT_EN.
package maze_pkg;

    // RGB332 colours: {r[2:0], g[2:0], b[1:0]}
    localparam logic [7:0] BLACK  = 8'h00;
    localparam logic [7:0] GRAY   = 8'h92;
    localparam logic [7:0] WALL   = 8'h49;
    localparam logic [7:0] RED    = 8'hE0;
    localparam logic [7:0] GREEN  = 8'h1C;
    localparam logic [7:0] BLUE   = 8'h03;
    localparam logic [7:0] WHITE  = 8'hFF;
    localparam logic [7:0] PURPLE = 8'hE3;

    // Colour for each cell code; entry 0 is the cleared/empty cell
    localparam logic [7:0] PALETTE [8] = '{
        BLACK, WHITE, RED, GREEN, BLUE, PURPLE, 8'hFC, 8'h1F
    };

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/maze_clear_seq.sv
// Bulk-clear sequencer: sweeps every cell index once, zeroing one cell per cycle.
// Takes NUM_CELLS cycles after clr_req; busy drops the cycle after the last cell.
// Holds wr_ready low while sweeping so writes are refused (not counted as errors).
module maze_clear_seq
    import maze_pkg::*;
#(
    parameter int NUM_CELLS = 20,
    parameter int IDX_W     = 5
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             wr_ready,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx
);

    clr_state_t       state, state_next;
    logic [IDX_W-1:0] idx_next;

    // State and sweep index registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= CLR_IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= idx_next;
        end
    end

    // Next state: start on request from idle, leave after the last index is swept
    always_comb begin
        state_next = state;
        idx_next   = clr_idx;
        case (state)
            CLR_IDLE: begin
                idx_next = '0;
                if (clr_req) begin
                    state_next = CLR_CLEAR;
                end
            end
            CLR_CLEAR: begin
                if (int'(clr_idx) == NUM_CELLS - 1) begin
                    state_next = CLR_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = clr_idx + IDX_W'(1);
                end
            end
            default: begin
                state_next = CLR_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Outputs: busy while sweeping, write port closed for the same period
    always_comb begin
        clr_busy = (state == CLR_CLEAR);
        clr_we   = clr_busy;
        wr_ready = !clr_busy;
    end

endmodule

// File: rtl/maze_grid_renderer.sv
// Maze cell store with valid/ready write port and a 2-stage pixel colouriser.
// pixel_color is exactly 2 cycles behind pix_x/pix_y regardless of writes.
// wr_ready is low only during a bulk clear; optional MAZE_CURSOR_HIGHLIGHT_EN.
module maze_grid_renderer
    import maze_pkg::*;
#(
    parameter int GRID_COLS       = 5,
    parameter int GRID_ROWS       = 4,
    parameter int CELL_PX         = 120,
    parameter int STATE_W         = 3,
    parameter int COORD_W         = 10,
    parameter bit LINE_EN_DEFAULT = 1'b1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic [7:0]         pixel_color,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_col,
    input  logic [1:0]         wr_row,
    input  logic [STATE_W-1:0] wr_value,
    input  logic               clr_req,
    output logic               clr_busy,
    output logic [7:0]         err_cnt
`ifdef MAZE_CURSOR_HIGHLIGHT_EN
    ,
    input  logic [2:0]         cur_col,
    input  logic [1:0]         cur_row
`endif
);

    localparam int NUM_CELLS = GRID_COLS * GRID_ROWS;
    localparam int IDX_W     = $clog2(NUM_CELLS);

    logic [STATE_W-1:0] cells [GRID_ROWS][GRID_COLS];

    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;

    maze_clear_seq #(
        .NUM_CELLS (NUM_CELLS),
        .IDX_W     (IDX_W)
    ) u_clear_seq (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .wr_ready (wr_ready),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    logic wr_fire, wr_in_range;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (int'(wr_col) < GRID_COLS) && (int'(wr_row) < GRID_ROWS);

    // Cell array: sweep zeroing and accepted in-range writes (never coincide)
    always_ff @(posedge CLOCK_50) begin
        for (int r = 0; r < GRID_ROWS; r++) begin
            for (int c = 0; c < GRID_COLS; c++) begin
                if (reset) begin
                    cells[r][c] <= '0;
                end else if (clr_we && int'(clr_idx) == r * GRID_COLS + c) begin
                    cells[r][c] <= '0;
                end else if (wr_fire && wr_in_range &&
                             int'(wr_row) == r && int'(wr_col) == c) begin
                    cells[r][c] <= wr_value;
                end
            end
        end
    end

    // Saturating count of accepted writes that fell outside the grid
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (wr_fire && !wr_in_range && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    // Stage 1 combinational decode of the pixel coordinate
    logic [COORD_W-1:0] x_cell, y_cell;
    logic               in_grid, on_edge;
    assign x_cell  = pix_x / COORD_W'(CELL_PX);
    assign y_cell  = pix_y / COORD_W'(CELL_PX);
    assign in_grid = (x_cell < COORD_W'(GRID_COLS)) && (y_cell < COORD_W'(GRID_ROWS));
    assign on_edge = ((pix_x % COORD_W'(CELL_PX)) == '0) ||
                     ((pix_y % COORD_W'(CELL_PX)) == '0);

    logic [2:0] s1_col;
    logic [1:0] s1_row;
    logic       s1_in_grid, s1_on_edge, s1_cur_hit;

`ifdef MAZE_CURSOR_HIGHLIGHT_EN
    logic cur_hit;
    assign cur_hit = (int'(cur_col) < GRID_COLS) && (int'(cur_row) < GRID_ROWS) &&
                     (COORD_W'(cur_col) == x_cell) && (COORD_W'(cur_row) == y_cell);
`else
    logic cur_hit;
    assign cur_hit = 1'b0;
`endif

    // Stage 1 registers: cell coordinates, region flags and cursor match
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_col     <= '0;
            s1_row     <= '0;
            s1_in_grid <= 1'b0;
            s1_on_edge <= 1'b0;
            s1_cur_hit <= 1'b0;
        end else begin
            s1_col     <= x_cell[2:0];
            s1_row     <= y_cell[1:0];
            s1_in_grid <= in_grid;
            s1_on_edge <= on_edge;
            s1_cur_hit <= cur_hit;
        end
    end

    // Cell read happens against the pre-edge array, so a same-cycle write shows next cycle
    logic [STATE_W-1:0] s1_cell;
    logic [7:0]         s1_pal;
    assign s1_cell = cells[s1_row][s1_col];
    assign s1_pal  = PALETTE[s1_cell];

    // Stage 2: pick outside/grid-line/cell colour, inverting a highlighted cell
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pixel_color <= BLACK;
        end else if (!s1_in_grid) begin
            pixel_color <= GRAY;
        end else if (s1_on_edge && LINE_EN_DEFAULT) begin
            pixel_color <= WALL;
        end else if (s1_cur_hit && !s1_on_edge) begin
            pixel_color <= ~s1_pal;
        end else begin
            pixel_color <= s1_pal;
        end
    end

endmodule
